// File: rtl/light_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : light_sequencer                                               |
// | Purpose  : Palette-driven light selector with manual/auto stepping,      |
// |            white and off modes, and a registered packed light output.    |
// | Options  : FADE_EN - slew light toward target by 1 LSB/channel/clock.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module light_sequencer #(
  parameter int CH_W       = 8,
  parameter int N_COLOURS  = 6,
  parameter int STEP_TICKS = 50000000,
  localparam int IDX_W     = ($clog2(N_COLOURS) < 1) ? 1 : $clog2(N_COLOURS),
  localparam int LW        = 3 * CH_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             button,
  input  logic             pal_we,
  input  logic [IDX_W-1:0] pal_addr,
  input  logic [LW-1:0]    pal_data,
  output logic [LW-1:0]    light,
  output logic [IDX_W-1:0] colour_idx,
  output logic             step,
  output logic             fading
);

  localparam int TICK_W = ($clog2(STEP_TICKS) < 1) ? 1 : $clog2(STEP_TICKS);

  localparam logic [1:0] c_MODE_WHITE  = 2'b00;
  localparam logic [1:0] c_MODE_MANUAL = 2'b01;
  localparam logic [1:0] c_MODE_AUTO   = 2'b10;
  localparam logic [1:0] c_MODE_OFF    = 2'b11;

  localparam logic [TICK_W-1:0] c_TICK_LAST = TICK_W'(STEP_TICKS - 1);
  localparam logic [IDX_W-1:0]  c_IDX_LAST  = IDX_W'(N_COLOURS - 1);

  // Reset palette: 3-bit code (i mod 6)+1 spread to full-scale channels {R,G,B}.
  function automatic logic [LW-1:0] default_entry(input int i);
    logic [2:0] code;
    code = 3'((i % 6) + 1);
    return {{CH_W{code[2]}}, {CH_W{code[1]}}, {CH_W{code[0]}}};
  endfunction

  logic [LW-1:0]     r_palette [N_COLOURS];
  logic [LW-1:0]     r_light;
  logic [IDX_W-1:0]  r_idx;
  logic              r_step;
  logic              r_fading;
  logic              r_btn_q;
  logic [TICK_W-1:0] r_tick;

  logic              w_btn_rise;
  logic              w_adv;
  logic              w_addr_ok;
  logic [IDX_W-1:0]  w_idx_next;
  logic [LW-1:0]     w_target;
  logic [LW-1:0]     w_light_next;
  logic              w_fading_next;

  assign w_btn_rise = button & ~r_btn_q;
  assign w_addr_ok  = 32'(pal_addr) < 32'(N_COLOURS);
  assign w_idx_next = (r_idx == c_IDX_LAST) ? '0 : r_idx + IDX_W'(1);

  always_comb begin
    w_adv = 1'b0;
    case (mode)
      c_MODE_MANUAL: w_adv = w_btn_rise;
      c_MODE_AUTO:   w_adv = (r_tick == c_TICK_LAST);
      default:       w_adv = 1'b0;
    endcase
  end

  // Target reads the registered index, so a new colour lands one edge after the step.
  always_comb begin
    w_target = '0;
    case (mode)
      c_MODE_WHITE:  w_target = '1;
      c_MODE_MANUAL: w_target = r_palette[r_idx];
      c_MODE_AUTO:   w_target = r_palette[r_idx];
      c_MODE_OFF:    w_target = '0;
      default:       w_target = '0;
    endcase
  end

`ifdef FADE_EN
  for (genvar ch = 0; ch < 3; ch++) begin : g_fade_ch
    logic [CH_W-1:0] w_cur;
    logic [CH_W-1:0] w_tgt;
    assign w_cur = r_light[ch*CH_W +: CH_W];
    assign w_tgt = w_target[ch*CH_W +: CH_W];
    assign w_light_next[ch*CH_W +: CH_W] =
        (w_cur < w_tgt) ? w_cur + CH_W'(1) :
        (w_cur > w_tgt) ? w_cur - CH_W'(1) : w_cur;
  end
  assign w_fading_next = (w_light_next != w_target);
`else
  assign w_light_next  = w_target;
  assign w_fading_next = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_light  <= '0;
      r_idx    <= '0;
      r_step   <= 1'b0;
      r_fading <= 1'b0;
      r_btn_q  <= 1'b0;
      r_tick   <= '0;
      for (int i = 0; i < N_COLOURS; i++) begin
        r_palette[i] <= default_entry(i);
      end
    end else begin
      r_btn_q  <= button;
      r_step   <= w_adv;
      r_light  <= w_light_next;
      r_fading <= w_fading_next;

      if (w_adv) begin
        r_idx <= w_idx_next;
      end

      // Held at zero outside auto so entering auto always waits a full period.
      if ((mode != c_MODE_AUTO) || w_adv) begin
        r_tick <= '0;
      end else begin
        r_tick <= r_tick + TICK_W'(1);
      end

      if (pal_we && w_addr_ok) begin
        r_palette[pal_addr] <= pal_data;
      end
    end
  end

  assign light      = r_light;
  assign colour_idx = r_idx;
  assign step       = r_step;
  assign fading     = r_fading;

endmodule
`default_nettype wire

// File: tb/tb_light_sequencer.sv
`default_nettype none
// Directed self-checking bench for light_sequencer (default build, STEP_TICKS=4).
module tb_light_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        button;
  logic        pal_we;
  logic [2:0]  pal_addr;
  logic [23:0] pal_data;
  logic [23:0] light;
  logic [2:0]  colour_idx;
  logic        step;
  logic        fading;

  int n_cmp = 0;
  int n_err = 0;

  light_sequencer #(
    .CH_W       (8),
    .N_COLOURS  (6),
    .STEP_TICKS (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .button     (button),
    .pal_we     (pal_we),
    .pal_addr   (pal_addr),
    .pal_data   (pal_data),
    .light      (light),
    .colour_idx (colour_idx),
    .step       (step),
    .fading     (fading)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // One button press held 5 cycles; expects exactly one step pulse.
  task automatic press(input logic [2:0] exp_idx, input logic [23:0] exp_light);
    int pulses;
    pulses = 0;
    button = 1'b1;
    nxt();
    check("press_idx", 32'(colour_idx), 32'(exp_idx));
    pulses += int'(step);
    nxt();
    check("press_light", 32'(light), 32'(exp_light));
    pulses += int'(step);
    repeat (3) begin
      nxt();
      pulses += int'(step);
    end
    button = 1'b0;
    nxt();
    pulses += int'(step);
    check("press_pulses", 32'(pulses), 32'd1);
  endtask

  initial begin
    logic [2:0]  auto_idx   [3];
    logic [23:0] auto_light [3];
    auto_idx   = '{3'd4, 3'd5, 3'd0};
    auto_light = '{24'hFF00FF, 24'hFFFF00, 24'h0000FF};

    rst = 1'b1; mode = 2'b00; button = 1'b0;
    pal_we = 1'b0; pal_addr = '0; pal_data = '0;

    // Reset held 3 cycles in white mode
    repeat (3) begin
      nxt();
      check("rst_light", 32'(light), 32'h0);
    end
    check("rst_idx", 32'(colour_idx), 32'h0);
    check("rst_step", 32'(step), 32'h0);
    check("rst_fading", 32'(fading), 32'h0);
    rst = 1'b0;
    nxt();
    check("white_light", 32'(light), 32'hFFFFFF);
    check("white_idx", 32'(colour_idx), 32'h0);

    // Manual stepping
    mode = 2'b01;
    nxt();
    check("man0_light", 32'(light), 32'h0000FF);
    press(3'd1, 24'h00FF00);
    press(3'd2, 24'h00FFFF);
    press(3'd3, 24'hFF0000);

    // Auto stepping every 4 cycles with wrap
    mode = 2'b10;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++) begin
        nxt();
        if (j == 0 && k > 0) check("auto_light", 32'(light), 32'(auto_light[k-1]));
        if (j < 3) begin
          check("auto_nostep", 32'(step), 32'h0);
        end else begin
          check("auto_step", 32'(step), 32'h1);
          check("auto_idx", 32'(colour_idx), 32'(auto_idx[k]));
        end
      end
    end
    nxt();
    check("auto_light_last", 32'(light), 32'(auto_light[2]));

    // Palette writes in manual mode at idx 0
    mode = 2'b01;
    nxt();
    check("man_idx_hold", 32'(colour_idx), 32'h0);
    pal_we = 1'b1; pal_addr = 3'd0; pal_data = 24'h123456;
    nxt();
    check("wr_prev_light", 32'(light), 32'h0000FF);
    pal_we = 1'b0;
    nxt();
    check("wr_light", 32'(light), 32'h123456);
    pal_we = 1'b1; pal_addr = 3'd7; pal_data = 24'hABCDEF;
    nxt();
    pal_we = 1'b0;
    nxt();
    check("wr_oob_light", 32'(light), 32'h123456);
    press(3'd1, 24'h00FF00);
    mode = 2'b11;
    nxt();
    check("off_light", 32'(light), 32'h0);
    check("off_idx", 32'(colour_idx), 32'h1);

    // Reset from auto mode restores the palette
    mode = 2'b01;
    nxt();
    press(3'd2, 24'h00FFFF);
    mode = 2'b10;
    nxt();
    nxt();
    check("pre_rst_light", 32'(light), 32'h00FFFF);
    check("pre_rst_idx", 32'(colour_idx), 32'h2);
    rst = 1'b1;
    nxt();
    check("rst2_idx", 32'(colour_idx), 32'h0);
    check("rst2_light", 32'(light), 32'h0);
    check("rst2_step", 32'(step), 32'h0);
    rst = 1'b0; mode = 2'b01;
    nxt();
    check("restored_light", 32'(light), 32'h0000FF);

    // Simultaneous write and advance to the same entry
    button = 1'b1; pal_we = 1'b1; pal_addr = 3'd1; pal_data = 24'h654321;
    nxt();
    check("both_idx", 32'(colour_idx), 32'h1);
    check("both_step", 32'(step), 32'h1);
    button = 1'b0; pal_we = 1'b0;
    nxt();
    check("both_light", 32'(light), 32'h654321);
    nxt();

    // Manual wrap from the last entry
    press(3'd2, 24'h00FFFF);
    press(3'd3, 24'hFF0000);
    press(3'd4, 24'hFF00FF);
    press(3'd5, 24'hFFFF00);
    press(3'd0, 24'h0000FF);
    check("end_fading", 32'(fading), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
